// File: rtl/fsm_ab_pkg.sv
// Shared types and golden-model rules for the a/b sequence FSM driver.
// Control states, model states and next-state/output helpers.
package fsm_ab_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRIVE,
    DONE
  } ctrl_e;

  typedef enum logic [1:0] {
    S0,
    S1,
    S2
  } mst_e;

  function automatic mst_e mst_next(
    input mst_e s,
    input logic a,
    input logic b
  );
    mst_e n;
    n = S0;
    case (s)
      S0: begin
        if (a && b)
          n = S2;
        else if (a)
          n = S1;
        else
          n = S0;
      end
      S1: n = a ? S0 : S1;
      default: n = S0;
    endcase
    return n;
  endfunction

  function automatic logic exp_y0_f(
    input mst_e s,
    input logic a,
    input logic b
  );
    return (s == S0) && a && b;
  endfunction

  function automatic logic exp_y1_f(input mst_e s);
    return (s == S1) || (s == S2);
  endfunction

endpackage

// File: rtl/fsm_ab_if.sv
// Link between the driver and the FSM under test.
// Driver owns reset and a/b; the FSM returns y0/y1.
interface fsm_ab_if;
  logic dut_rst;
  logic a;
  logic b;
  logic y0;
  logic y1;

  modport master (
    output dut_rst,
    output a,
    output b,
    input  y0,
    input  y1
  );

  modport slave (
    input  dut_rst,
    input  a,
    input  b,
    output y0,
    output y1
  );
endinterface

// File: rtl/fsm_ab_model.sv
// Registered golden model of the a/b sequence FSM.
// Expected y0 is Mealy on the live a/b; y1 is Moore.
module fsm_ab_model
  import fsm_ab_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic step_en,
  input  logic a,
  input  logic b,
  output logic exp_y0,
  output logic exp_y1
);

  mst_e st_q;
  mst_e st_d;

  always_comb begin
    st_d = st_q;
    if (clear)
      st_d = S0;
    else if (step_en)
      st_d = mst_next(st_q, a, b);
  end

  always_ff @(posedge clk) begin
    if (reset)
      st_q <= S0;
    else
      st_q <= st_d;
  end

  assign exp_y0 = exp_y0_f(st_q, a, b);
  assign exp_y1 = exp_y1_f(st_q);

endmodule

// File: rtl/fsm_ab_driver.sv
// Stimulus/response driver for the a/b sequence FSM.
// Resets it, plays a loaded pattern, counts output mismatches.
module fsm_ab_driver
  import fsm_ab_pkg::*;
#(
  parameter int LEN   = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN-1:0]   pat_a,
  input  logic [LEN-1:0]   pat_b,
  fsm_ab_if.master         dut,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic             pass
);

  localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [IW-1:0] LAST = IW'(LEN - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  ctrl_e            st_q, st_d;
  logic [LEN-1:0]   sa_q, sa_d;
  logic [LEN-1:0]   sb_q, sb_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;

  logic in_drive;
  logic a_w;
  logic b_w;
  logic exp_y0;
  logic exp_y1;
  logic mis;

  assign in_drive = (st_q == DRIVE);
  assign a_w = in_drive & sa_q[0];
  assign b_w = in_drive & sb_q[0];
  assign mis = in_drive &
               ((dut.y0 != exp_y0) |
                (dut.y1 != exp_y1));

  always_comb begin
    st_d   = st_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    idx_d  = idx_q;
    err_d  = err_q;
    pass_d = pass_q;
    case (st_q)
      IDLE: begin
        if (start) begin
          st_d   = LOAD;
          sa_d   = pat_a;
          sb_d   = pat_b;
          idx_d  = '0;
          err_d  = '0;
          pass_d = 1'b0;
        end
      end
      LOAD: st_d = DRIVE;
      DRIVE: begin
        sa_d = sa_q >> 1;
        sb_d = sb_q >> 1;
        if (mis && (err_q != CMAX))
          err_d = err_q + 1'b1;
        // last step's mismatch must count toward pass
        if (idx_q == LAST) begin
          st_d   = DONE;
          pass_d = (err_d == '0);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= IDLE;
      sa_q   <= '0;
      sb_q   <= '0;
      idx_q  <= '0;
      err_q  <= '0;
      pass_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      idx_q  <= idx_d;
      err_q  <= err_d;
      pass_q <= pass_d;
    end
  end

  fsm_ab_model u_model (
    .clk     (clk),
    .reset   (reset),
    .clear   (st_q == LOAD),
    .step_en (in_drive),
    .a       (a_w),
    .b       (b_w),
    .exp_y0  (exp_y0),
    .exp_y1  (exp_y1)
  );

  assign dut.dut_rst = (st_q == LOAD);
  assign dut.a       = a_w;
  assign dut.b       = b_w;
  assign busy        = (st_q != IDLE);
  assign done        = (st_q == DONE);
  assign err_count   = err_q;
  assign pass        = pass_q;

endmodule

// File: tb/tb_fsm_ab_driver.sv
// Bench for fsm_ab_driver: a behavioural FSM with fault modes on
// the far side, results checked against a pattern-walk reference.
module tb_fsm_ab_driver;

  localparam int LEN = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pat_a = '0;
  logic [7:0] pat_b = '0;
  logic       busy;
  logic       done;
  logic [7:0] err_count;
  logic       pass;

  logic       start2 = 1'b0;
  logic       busy2;
  logic       done2;
  logic [1:0] err2;
  logic       pass2;

  int fmode = 0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fsm_ab_if bus ();
  fsm_ab_if bus2 ();

  fsm_ab_driver #(.LEN(LEN), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pat_a     (pat_a),
    .pat_b     (pat_b),
    .dut       (bus.master),
    .busy      (busy),
    .done      (done),
    .err_count (err_count),
    .pass      (pass)
  );

  fsm_ab_driver #(.LEN(LEN), .CNT_W(2)) dut2 (
    .clk       (clk),
    .reset     (reset),
    .start     (start2),
    .pat_a     (8'h00),
    .pat_b     (8'h00),
    .dut       (bus2.master),
    .busy      (busy2),
    .done      (done2),
    .err_count (err2),
    .pass      (pass2)
  );

  // FSM under test; fmode 1: y1 stuck 0, 2: y0 stuck 1,
  // 3: y1 inverted, 4: y0 inverted
  int fs = 0;
  always @(posedge clk) begin
    if (bus.dut_rst)
      fs <= 0;
    else if (fs == 0)
      fs <= bus.a ? (bus.b ? 2 : 1) : 0;
    else if (fs == 1)
      fs <= bus.a ? 0 : 1;
    else
      fs <= 0;
  end

  logic y0_ok;
  logic y1_ok;
  assign y0_ok = (fs == 0) && bus.a && bus.b;
  assign y1_ok = (fs != 0);
  assign bus.y0 = (fmode == 2) ? 1'b1 :
                  (fmode == 4) ? ~y0_ok : y0_ok;
  assign bus.y1 = (fmode == 1) ? 1'b0 :
                  (fmode == 3) ? ~y1_ok : y1_ok;

  assign bus2.y0 = 1'b1;
  assign bus2.y1 = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Walk the pattern through the sequence rules and count
  // the steps where the faulty outputs disagree.
  function automatic int ref_errs(input logic [7:0] pa,
                                  input logic [7:0] pb,
                                  input int mode);
    int s = 0;
    int n = 0;
    for (int i = 0; i < LEN; i++) begin
      bit ai = pa[i];
      bit bi = pb[i];
      bit ey0 = (s == 0) && ai && bi;
      bit ey1 = (s != 0);
      bit gy0 = ey0;
      bit gy1 = ey1;
      if (mode == 1) gy1 = 0;
      if (mode == 2) gy0 = 1;
      if (mode == 3) gy1 = !ey1;
      if (mode == 4) gy0 = !ey0;
      if (gy0 != ey0 || gy1 != ey1) n++;
      if (s == 0) s = ai ? (bi ? 2 : 1) : 0;
      else if (s == 1) s = ai ? 0 : 1;
      else s = 0;
    end
    return (n > 255) ? 255 : n;
  endfunction

  task automatic run(input logic [7:0] pa,
                     input logic [7:0] pb,
                     input int mode,
                     input int exp_err,
                     input bit poke);
    @(negedge clk);
    start = 1'b1;
    pat_a = pa;
    pat_b = pb;
    fmode = mode;
    @(posedge clk);
    #1 start = 1'b0;
    check("load_rst", bus.dut_rst, 1);
    check("load_busy", busy, 1);
    check("load_ab", {bus.a, bus.b}, 0);
    for (int i = 0; i < LEN; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      check("drv_a", bus.a, pa[i]);
      check("drv_b", bus.b, pb[i]);
      check("drv_rst", bus.dut_rst, 0);
      check("drv_done", done, 0);
      check("drv_busy", busy, 1);
      if (poke && i == 3)
        start = 1'b1;
    end
    @(posedge clk);
    #1 start = 1'b0;
    check("done", done, 1);
    check("done_ab", {bus.a, bus.b}, 0);
    check("err", err_count, exp_err);
    check("pass", pass, exp_err == 0);
    @(posedge clk);
    #1;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("hold_err", err_count, exp_err);
    check("hold_pass", pass, exp_err == 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_count, 0);
    check("rst_pass", pass, 0);
    check("rst_dutrst", bus.dut_rst, 0);
    reset = 1'b0;

    run(8'b00000011, 8'b00000001, 0, 0, 0);
    run(8'b00000101, 8'b00000000, 0, 0, 0);
    run(8'b00000101, 8'b00000000, 1, 2, 0);
    run(8'b00000011, 8'b00000001, 1, 1, 0);
    run(8'b00000011, 8'b00000001, 0, 0, 1);
    run(8'b10110110, 8'b01100011, 0, 0, 0);

    for (int k = 0; k < 12; k++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      int m;
      ra = 8'($urandom);
      rb = 8'($urandom);
      m = int'($urandom_range(0, 4));
      run(ra, rb, m, ref_errs(ra, rb, m), k[0]);
    end

    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    check("sat_busy", busy2, 1);
    repeat (LEN) @(posedge clk);
    @(posedge clk);
    #1;
    check("sat_done", done2, 1);
    check("sat_err", err2, 3);
    check("sat_pass", pass2, 0);

    @(negedge clk);
    start = 1'b1;
    pat_a = 8'hff;
    pat_b = 8'h00;
    fmode = 3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_ab", {bus.a, bus.b}, 0);
    check("mrst_done", done, 0);
    check("mrst_err", err_count, 0);
    check("mrst_pass", pass, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    check("mrst2_busy", busy, 0);
    check("mrst2_err", err_count, 0);
    @(posedge clk);
    #1;
    check("post_rst_idle", busy, 0);

    run(8'b00000011, 8'b00000001, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
